// File: rtl/ip_frag_ctrl_pkg.sv
// Shared types and constants for the single-context IP fragment reassembly controller.
package ip_frag_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWhole,
    StFrag,
    StAssem,
    StCheck,
    StReady,
    StDisc
  } state_e;

  // Fragment offsets arrive in 8-byte units.
  localparam int unsigned FragUnitShift = 3;

  function automatic logic [15:0] frag_base(input logic [12:0] sft);
    return 16'(sft) << FragUnitShift;
  endfunction

endpackage

// File: rtl/ip_frag_ctrl_timer.sv
// Reassembly idle timer: counts enabled cycles and pulses expired_o after TO_CYC of them.
module ip_frag_ctrl_timer #(
  parameter int unsigned     TO_W   = 24,
  parameter logic [TO_W-1:0] TO_CYC = 24'd12500000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  logic [TO_W-1:0] cnt_q, cnt_d;

  assign expired_o = en_i && !clr_i && (cnt_q == TO_CYC - 1'b1);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || expired_o) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ip_frag_ctrl.sv
// Single-context IP reassembly controller: buffer write addressing, length tracking, hand-over.
// Optional statistics counters are built when IP_FRAG_STAT_EN is defined.
module ip_frag_ctrl
  import ip_frag_ctrl_pkg::*;
#(
  parameter int unsigned       BUF_AW = 11,
  parameter int unsigned       TO_W   = 24,
  parameter logic [TO_W-1:0]   TO_CYC = 24'd12500000
) (
  input  logic              rx_clk,
  input  logic              rst,
  input  logic              pkt_start,
  input  logic              frag_start,
  input  logic [12:0]       frag_sft,
  input  logic              last_frag,
  input  logic [31:0]       src_ip,
  input  logic              pkt_en,
  input  logic [7:0]        pkt_dat,
  input  logic              frag_end,
  input  logic              pkt_end,
  output logic              buf_we,
  output logic [BUF_AW-1:0] buf_addr,
  output logic [7:0]        buf_dat,
  output logic              asm_done,
  output logic [15:0]       asm_len,
  output logic [31:0]       asm_src_ip,
  input  logic              asm_ack,
  output logic              asm_drop,
  output logic              busy,
  output logic [15:0]       stat_asm_cnt,
  output logic [15:0]       stat_drop_cnt
);

  localparam logic [16:0] BufMax = 17'((17'd1 << BUF_AW) - 17'd1);

  state_e            state_q, state_d;
  logic [15:0]       base_q, base_d, offset_q, offset_d;
  logic [15:0]       rcv_q, rcv_d, tot_q, tot_d, asm_len_q, asm_len_d;
  logic [31:0]       ctx_ip_q, ctx_ip_d, asm_ip_q, asm_ip_d;
  logic              have_last_q, have_last_d, lf_q, lf_d;
  logic              we_q, we_d, drop_q, drop_d;
  logic [BUF_AW-1:0] addr_q, addr_d;
  logic [7:0]        dat_q, dat_d;
  logic [16:0]       wr_addr;
  logic              tmr_clr, tmr_en, tmr_exp, accept_start, any_start;

  assign wr_addr   = {1'b0, base_q} + {1'b0, offset_q};
  assign any_start = pkt_start || frag_start;

  ip_frag_ctrl_timer #(
    .TO_W   (TO_W),
    .TO_CYC (TO_CYC)
  ) u_timer (
    .clk_i     (rx_clk),
    .rst_i     (rst),
    .clr_i     (tmr_clr),
    .en_i      (tmr_en),
    .expired_o (tmr_exp)
  );

  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    offset_d     = offset_q;
    rcv_d        = rcv_q;
    tot_d        = tot_q;
    asm_len_d    = asm_len_q;
    ctx_ip_d     = ctx_ip_q;
    asm_ip_d     = asm_ip_q;
    have_last_d  = have_last_q;
    lf_d         = lf_q;
    we_d         = 1'b0;
    drop_d       = 1'b0;
    addr_d       = addr_q;
    dat_d        = dat_q;
    tmr_clr      = 1'b0;
    tmr_en       = 1'b0;
    accept_start = 1'b0;

    unique case (state_q)
      StIdle: accept_start = 1'b1;
      StWhole, StFrag: begin
        if (state_q == StWhole && pkt_end) begin
          asm_len_d = offset_q;
          asm_ip_d  = ctx_ip_q;
          state_d   = StReady;
          drop_d    = any_start;
        end else if (state_q == StFrag && frag_end) begin
          rcv_d   = rcv_q + offset_q;
          if (lf_q) begin
            tot_d       = wr_addr[15:0];
            have_last_d = 1'b1;
          end
          state_d = StCheck;
          drop_d  = any_start;
        end else if (pkt_en) begin
          if (wr_addr > BufMax) begin
            drop_d  = 1'b1;
            state_d = StDisc;
          end else begin
            we_d     = 1'b1;
            addr_d   = wr_addr[BUF_AW-1:0];
            dat_d    = pkt_dat;
            offset_d = offset_q + 16'd1;
          end
        end
      end
      StCheck: begin
        drop_d = any_start;
        if (have_last_q && rcv_q == tot_q) begin
          asm_len_d = tot_q;
          asm_ip_d  = ctx_ip_q;
          state_d   = StReady;
        end else begin
          tmr_clr = 1'b1;
          state_d = StAssem;
        end
      end
      StAssem: begin
        tmr_en = 1'b1;
        if (tmr_exp) begin
          drop_d  = 1'b1;
          state_d = StIdle;
        end else if (frag_start && src_ip == ctx_ip_q) begin
          base_d   = frag_base(frag_sft);
          offset_d = '0;
          lf_d     = last_frag;
          state_d  = StFrag;
        end else if (any_start) begin
          drop_d = 1'b1;
        end
      end
      StReady: begin
        drop_d = any_start;
        if (asm_ack) state_d = StIdle;
      end
      StDisc: begin
        // Terminating end is consumed first; a start in the same cycle opens a new context.
        if (pkt_end || frag_end) begin
          state_d      = StIdle;
          accept_start = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (state_d == StIdle) begin
      rcv_d       = '0;
      tot_d       = '0;
      have_last_d = 1'b0;
    end

    if (accept_start) begin
      if (pkt_start) begin
        state_d  = StWhole;
        base_d   = '0;
        offset_d = '0;
        ctx_ip_d = src_ip;
      end else if (frag_start) begin
        state_d     = StFrag;
        base_d      = frag_base(frag_sft);
        offset_d    = '0;
        ctx_ip_d    = src_ip;
        lf_d        = last_frag;
        rcv_d       = '0;
        tot_d       = '0;
        have_last_d = 1'b0;
      end
    end
  end

  always_ff @(posedge rx_clk) begin
    if (rst) begin
      state_q     <= StIdle;
      base_q      <= '0;
      offset_q    <= '0;
      rcv_q       <= '0;
      tot_q       <= '0;
      asm_len_q   <= '0;
      ctx_ip_q    <= '0;
      asm_ip_q    <= '0;
      have_last_q <= 1'b0;
      lf_q        <= 1'b0;
      we_q        <= 1'b0;
      drop_q      <= 1'b0;
      addr_q      <= '0;
      dat_q       <= '0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      offset_q    <= offset_d;
      rcv_q       <= rcv_d;
      tot_q       <= tot_d;
      asm_len_q   <= asm_len_d;
      ctx_ip_q    <= ctx_ip_d;
      asm_ip_q    <= asm_ip_d;
      have_last_q <= have_last_d;
      lf_q        <= lf_d;
      we_q        <= we_d;
      drop_q      <= drop_d;
      addr_q      <= addr_d;
      dat_q       <= dat_d;
    end
  end

  assign buf_we     = we_q;
  assign buf_addr   = addr_q;
  assign buf_dat    = dat_q;
  assign asm_done   = (state_q == StReady);
  assign asm_len    = asm_len_q;
  assign asm_src_ip = asm_ip_q;
  assign asm_drop   = drop_q;
  assign busy       = (state_q != StIdle);

`ifdef IP_FRAG_STAT_EN
  logic [15:0] stat_asm_q, stat_asm_d, stat_drop_q, stat_drop_d;

  always_comb begin
    stat_asm_d  = stat_asm_q;
    stat_drop_d = stat_drop_q;
    if (state_d == StReady && state_q != StReady && stat_asm_q != 16'hFFFF) begin
      stat_asm_d = stat_asm_q + 16'd1;
    end
    if (drop_d && stat_drop_q != 16'hFFFF) begin
      stat_drop_d = stat_drop_q + 16'd1;
    end
  end

  always_ff @(posedge rx_clk) begin
    if (rst) begin
      stat_asm_q  <= '0;
      stat_drop_q <= '0;
    end else begin
      stat_asm_q  <= stat_asm_d;
      stat_drop_q <= stat_drop_d;
    end
  end

  assign stat_asm_cnt  = stat_asm_q;
  assign stat_drop_cnt = stat_drop_q;
`else
  assign stat_asm_cnt  = 16'h0;
  assign stat_drop_cnt = 16'h0;
`endif

endmodule

// File: tb/tb_ip_frag_ctrl.sv
// Directed self-checking bench for ip_frag_ctrl (short timeout so expiry is reachable).
module tb_ip_frag_ctrl;

  localparam int unsigned BufAw = 11;

  logic             rx_clk = 1'b0;
  logic             rst = 1'b1;
  logic             pkt_start = 1'b0, frag_start = 1'b0, last_frag = 1'b0;
  logic [12:0]      frag_sft = '0;
  logic [31:0]      src_ip = '0;
  logic             pkt_en = 1'b0, frag_end = 1'b0, pkt_end = 1'b0, asm_ack = 1'b0;
  logic [7:0]       pkt_dat = '0;
  logic             buf_we, asm_done, asm_drop, busy;
  logic [BufAw-1:0] buf_addr;
  logic [7:0]       buf_dat;
  logic [15:0]      asm_len, stat_asm_cnt, stat_drop_cnt;
  logic [31:0]      asm_src_ip;

  int checks = 0;
  int errors = 0;
  int drops  = 0;
  logic [BufAw-1:0] wa[$];
  logic [7:0]       wd[$];

  ip_frag_ctrl #(
    .BUF_AW (BufAw),
    .TO_W   (24),
    .TO_CYC (24'd50)
  ) dut (
    .rx_clk        (rx_clk),
    .rst           (rst),
    .pkt_start     (pkt_start),
    .frag_start    (frag_start),
    .frag_sft      (frag_sft),
    .last_frag     (last_frag),
    .src_ip        (src_ip),
    .pkt_en        (pkt_en),
    .pkt_dat       (pkt_dat),
    .frag_end      (frag_end),
    .pkt_end       (pkt_end),
    .buf_we        (buf_we),
    .buf_addr      (buf_addr),
    .buf_dat       (buf_dat),
    .asm_done      (asm_done),
    .asm_len       (asm_len),
    .asm_src_ip    (asm_src_ip),
    .asm_ack       (asm_ack),
    .asm_drop      (asm_drop),
    .busy          (busy),
    .stat_asm_cnt  (stat_asm_cnt),
    .stat_drop_cnt (stat_drop_cnt)
  );

  always #4 rx_clk = ~rx_clk;

  // Record buffer writes and drop pulses mid-cycle, away from the active edge.
  always @(negedge rx_clk) begin
    if (buf_we) begin
      wa.push_back(buf_addr);
      wd.push_back(buf_dat);
    end
    if (asm_drop) drops++;
  end

  task automatic tick();
    @(posedge rx_clk);
    #1;
  endtask

  task automatic clear_log();
    wa.delete();
    wd.delete();
    drops = 0;
  endtask

  task automatic start_frag(input logic [12:0] sft, input logic last, input logic [31:0] ip);
    frag_start = 1'b1; frag_sft = sft; last_frag = last; src_ip = ip;
    tick();
    frag_start = 1'b0;
  endtask

  task automatic send_bytes(input int n, input logic [7:0] first);
    for (int i = 0; i < n; i++) begin
      pkt_en = 1'b1; pkt_dat = first + 8'(i);
      tick();
    end
    pkt_en = 1'b0;
  endtask

  task automatic end_frag();
    frag_end = 1'b1;
    tick();
    frag_end = 1'b0;
  endtask

  task automatic ack();
    asm_ack = 1'b1;
    tick();
    asm_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
    checks++;
    if (buf_we !== 1'b0 || asm_drop !== 1'b0 || asm_done !== 1'b0) begin
      errors++; $display("FAIL reset_strobes got we=%0b drop=%0b done=%0b want 0", buf_we, asm_drop, asm_done);
    end
    checks++;
    if (asm_len !== 16'd0 || asm_src_ip !== 32'd0 || buf_addr !== '0) begin
      errors++; $display("FAIL reset_data got len=%0d ip=%0h addr=%0d want 0", asm_len, asm_src_ip, buf_addr);
    end
  endtask

  task automatic test_whole();
    clear_log();
    pkt_start = 1'b1; src_ip = 32'hC0A80001;
    tick();
    pkt_start = 1'b0;
    send_bytes(100, 8'h00);
    pkt_end = 1'b1;
    tick();
    pkt_end = 1'b0;
    checks++;
    if (asm_done !== 1'b1 || asm_len !== 16'd100) begin
      errors++; $display("FAIL whole_done got done=%0b len=%0d want 1 100", asm_done, asm_len);
    end
    checks++;
    if (asm_src_ip !== 32'hC0A80001) begin
      errors++; $display("FAIL whole_ip got %0h want c0a80001", asm_src_ip);
    end
    checks++;
    if (wa.size() != 100) begin errors++; $display("FAIL whole_nwr got %0d want 100", wa.size()); end
    for (int i = 0; i < 100; i++) begin
      checks++;
      if (i >= wa.size() || wa[i] !== 11'(i) || wd[i] !== 8'(i)) begin
        errors++; $display("FAIL whole_wr idx %0d got addr/dat mismatch want %0d", i, i);
      end
    end
    // A start while holding a finished datagram is refused with a drop.
    pkt_start = 1'b1;
    tick();
    pkt_start = 1'b0;
    tick();
    checks++;
    if (drops != 1 || asm_done !== 1'b1) begin
      errors++; $display("FAIL ready_start got drops=%0d done=%0b want 1 1", drops, asm_done);
    end
    ack();
    checks++;
    if (asm_done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL whole_ack got done=%0b busy=%0b want 0 0", asm_done, busy);
    end
  endtask

  task automatic test_frag_inorder();
    clear_log();
    start_frag(13'd0, 1'b0, 32'h0A000001);
    send_bytes(16, 8'hA0);
    end_frag();
    tick();
    start_frag(13'd2, 1'b1, 32'h0A000001);
    send_bytes(8, 8'hB0);
    end_frag();
    checks++;
    if (asm_done !== 1'b0) begin errors++; $display("FAIL inord_check got done=%0b want 0", asm_done); end
    tick();
    checks++;
    if (asm_done !== 1'b1 || asm_len !== 16'd24 || asm_src_ip !== 32'h0A000001) begin
      errors++; $display("FAIL inord_done got done=%0b len=%0d ip=%0h want 1 24 0a000001",
                         asm_done, asm_len, asm_src_ip);
    end
    checks++;
    if (wa.size() != 24) begin errors++; $display("FAIL inord_nwr got %0d want 24", wa.size()); end
    for (int i = 16; i < 24; i++) begin
      checks++;
      if (i >= wa.size() || wa[i] !== 11'(i) || wd[i] !== 8'hB0 + 8'(i - 16)) begin
        errors++; $display("FAIL inord_b idx %0d want addr %0d", i, i);
      end
    end
    ack();
  endtask

  task automatic test_frag_reverse();
    clear_log();
    start_frag(13'd2, 1'b1, 32'h0A000001);
    send_bytes(8, 8'h10);
    end_frag();
    tick();
    checks++;
    if (asm_done !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL rev_wait got done=%0b busy=%0b want 0 1", asm_done, busy);
    end
    start_frag(13'd0, 1'b0, 32'h0A000001);
    send_bytes(16, 8'h00);
    end_frag();
    tick();
    checks++;
    if (asm_done !== 1'b1 || asm_len !== 16'd24) begin
      errors++; $display("FAIL rev_done got done=%0b len=%0d want 1 24", asm_done, asm_len);
    end
    checks++;
    if (wa.size() != 24 || wa[0] !== 11'd16 || wa[8] !== 11'd0 || wa[23] !== 11'd15) begin
      errors++; $display("FAIL rev_addr got n=%0d want 24 with addrs 16/0/15", wa.size());
    end
    ack();
  endtask

  task automatic test_foreign_timeout();
    int waited;
    start_frag(13'd0, 1'b0, 32'h0A000001);
    send_bytes(16, 8'h00);
    end_frag();
    tick();
    clear_log();
    start_frag(13'd2, 1'b1, 32'h0A000002);
    send_bytes(8, 8'h55);
    end_frag();
    tick();
    checks++;
    if (drops != 1 || wa.size() != 0) begin
      errors++; $display("FAIL foreign got drops=%0d writes=%0d want 1 0", drops, wa.size());
    end
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL foreign_busy got %0b want 1", busy); end
    waited = 0;
    while (busy === 1'b1 && waited < 200) begin
      tick();
      waited++;
    end
    tick();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL timeout_idle got busy=%0b want 0", busy); end
    checks++;
    if (drops != 2) begin errors++; $display("FAIL timeout_drop got %0d want 2", drops); end
  endtask

  task automatic test_overflow();
    clear_log();
    start_frag(13'd255, 1'b1, 32'h0A000003);
    send_bytes(16, 8'h00);
    end_frag();
    tick();
    checks++;
    if (wa.size() != 8 || wa[0] !== 11'd2040 || wa[7] !== 11'd2047) begin
      errors++; $display("FAIL ovf_wr got n=%0d want 8 writes 2040..2047", wa.size());
    end
    checks++;
    if (drops != 1) begin errors++; $display("FAIL ovf_drop got %0d want 1", drops); end
    checks++;
    if (busy !== 1'b0 || asm_done !== 1'b0) begin
      errors++; $display("FAIL ovf_idle got busy=%0b done=%0b want 0 0", busy, asm_done);
    end
  endtask

  task automatic test_rst_mid();
    logic [15:0] exp_asm, exp_drop;
`ifdef IP_FRAG_STAT_EN
    exp_asm  = 16'd3;
    exp_drop = 16'd4;
`else
    exp_asm  = 16'd0;
    exp_drop = 16'd0;
`endif
    checks++;
    if (stat_asm_cnt !== exp_asm || stat_drop_cnt !== exp_drop) begin
      errors++; $display("FAIL stats got asm=%0d drop=%0d want %0d %0d",
                         stat_asm_cnt, stat_drop_cnt, exp_asm, exp_drop);
    end
    clear_log();
    start_frag(13'd0, 1'b0, 32'h0A000004);
    send_bytes(4, 8'h00);
    rst = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %0b want 0", busy); end
    rst = 1'b0;
    tick(); tick();
    checks++;
    if (drops != 0 || buf_we !== 1'b0) begin
      errors++; $display("FAIL rst_drop got drops=%0d we=%0b want 0 0", drops, buf_we);
    end
    checks++;
    if (stat_asm_cnt !== 16'd0 || stat_drop_cnt !== 16'd0) begin
      errors++; $display("FAIL rst_stats got %0d %0d want 0 0", stat_asm_cnt, stat_drop_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_whole();
    test_frag_inorder();
    test_frag_reverse();
    test_foreign_timeout();
    test_overflow();
    test_rst_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
